calc_sequencer: RTL

Sequencing controller that shares one 4-bit calculator datapath (14-bit `astr` command in, 4-bit result and 7-bit seven-segment code out) between two requesters. It arbitrates round-robin, drives a registered command word into the datapath, and waits a fixed settle latency. It then captures the result and seven-segment code and returns them through a valid/ready response channel tagged with the requester ID. It sits between the front-end operand sources (keypad/UART decoders) and the calculator/display path.

---
 rtl/calc_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer
//
// Shares one 4-bit calculator datapath between two requesters. Requests are
// arbitrated round-robin in IDLE. The granted operation is driven onto a
// registered command word and held for CalcLat cycles while the datapath
// settles. The datapath result and seven-segment code are then captured and
// returned on a valid/ready response channel tagged with the requester ID.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   reqN_valid_i/reqN_ready_o request handshake for requester N (N = 0, 1)
//   reqN_op_i                 00 add, 01 sub, 10 OR, 11 negate A
//   reqN_a_i, reqN_b_i        operands (B ignored by the datapath for negate)
//   calc_astr_o               registered datapath command {op, a, b, 4'b0000}
//   calc_res_i, calc_seg_i    datapath result and active-low segment code
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_id_o                  requester that issued the operation
//   rsp_res_o, rsp_seg_o      captured result and segment code
//   busy_o                    high whenever the sequencer is not idle
//   op_count_o                completed response handshakes, wraps at 256
//
// CalcLat must lie in 1..15.

module calc_sequencer #(
   parameter int unsigned CalcLat = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [1:0]  req0_op_i,
   input  logic [3:0]  req0_a_i,
   input  logic [3:0]  req0_b_i,

   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [1:0]  req1_op_i,
   input  logic [3:0]  req1_a_i,
   input  logic [3:0]  req1_b_i,

   output logic [13:0] calc_astr_o,
   input  logic [3:0]  calc_res_i,
   input  logic [6:0]  calc_seg_i,

   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_id_o,
   output logic [3:0]  rsp_res_o,
   output logic [6:0]  rsp_seg_o,

   output logic        busy_o,
   output logic [7:0]  op_count_o
);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   localparam logic [3:0] LatInit = 4'(CalcLat - 1);

   state_e      state_q;
   logic        rr_q;
   logic [3:0]  cnt_q;
   logic [13:0] calc_astr_q;
   logic        rsp_valid_q;
   logic        rsp_id_q;
   logic [3:0]  rsp_res_q;
   logic [6:0]  rsp_seg_q;
   logic [7:0]  op_count_q;

   // Arbitration. Grants are only offered in IDLE and are masked while reset
   // is asserted so no transfer can be seen by a requester during reset.
   logic idle_open;
   logic pick1;
   logic gnt0;
   logic gnt1;

   always_comb begin
      idle_open = (state_q == StIdle) & ~rst_i;
      // req1 wins when it is the only requester, or when both request and
      // the round-robin pointer favours it.
      pick1     = req1_valid_i & (~req0_valid_i | rr_q);
      gnt1      = idle_open & pick1;
      gnt0      = idle_open & req0_valid_i & ~pick1;
   end

   assign req0_ready_o = gnt0;
   assign req1_ready_o = gnt1;

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         rr_q        <= 1'b0;
         cnt_q       <= 4'd0;
         calc_astr_q <= 14'd0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_res_q   <= 4'd0;
         rsp_seg_q   <= 7'd0;
         op_count_q  <= 8'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (gnt0 || gnt1) begin
                  if (gnt1) begin
                     calc_astr_q <= {req1_op_i, req1_a_i, req1_b_i, 4'b0000};
                  end else begin
                     calc_astr_q <= {req0_op_i, req0_a_i, req0_b_i, 4'b0000};
                  end
                  rsp_id_q <= gnt1;
                  // Pointer moves to the requester that was not just served.
                  rr_q     <= ~gnt1;
                  cnt_q    <= LatInit;
                  state_q  <= StWait;
               end
            end

            StWait: begin
               // Command has been stable for CalcLat cycles once cnt_q hits 0.
               if (cnt_q == 4'd0) begin
                  rsp_res_q   <= calc_res_i;
                  rsp_seg_q   <= calc_seg_i;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StResp;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end

            StResp: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  op_count_q  <= op_count_q + 8'd1;
                  state_q     <= StIdle;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign calc_astr_o = calc_astr_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_res_o   = rsp_res_q;
   assign rsp_seg_o   = rsp_seg_q;
   assign busy_o      = (state_q != StIdle);
   assign op_count_o  = op_count_q;

endmodule
